// File: rtl/sync_filter_multi_if.sv
// Boundary bundle for sync_filter_multi: the asynchronous level inputs
// and the synchronised level, strobes and change flag that come back.
// There is no valid/ready pair: d is sampled every clock with no
// acknowledgement, and q/rise/fall/chg are valid on every cycle outside reset.
interface sync_filter_multi_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             chg;

    // Source side: drives the raw levels, observes the synchronised view.
    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  chg
    );

    // Synchroniser side.
    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output chg
    );
endinterface

// File: rtl/sync_filter_multi.sv
// Multi-bit level synchroniser with optional per-bit glitch filter.
// Each of the WIDTH bits goes through its own DEPTH-flop chain.
// An optional stability counter then requires FILT extra consecutive
// samples at the new level before q follows.
// Registered rise/fall strobes mark the cycle q changes.
// The bits are unrelated: there is no cross-bit coherency, so multi-bit
// values must be gray coded or handshaked elsewhere.
module sync_filter_multi #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               FILT    = 0
) (
    input  logic               clk,
    input  logic               clr_,
    sync_filter_multi_if.slave bus
);

    // Counter wide enough to reach FILT; a FILT of 0 still keeps one bit so
    // the comparison below stays well formed.
    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);
    localparam logic [CW-1:0] FILT_C = CW'(FILT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Reject configurations that cannot be built.
    if (WIDTH < 1) begin : g_err_width
        $error("sync_filter_multi: WIDTH must be at least 1");
    end
    if (DEPTH < 2) begin : g_err_depth
        $error("sync_filter_multi: DEPTH must be at least 2");
    end
    if (FILT > 65535) begin : g_err_filt
        $error("sync_filter_multi: FILT must not exceed 65535");
    end

    // Synchroniser chain: index 0 is the first capture flop, DEPTH-1 the
    // last.  Nothing but wires between stages, to keep metastability
    // settling time as long as possible.
    logic [DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [DEPTH-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]            s;

    // Filter / output state, one counter per bit.
    logic [WIDTH-1:0][CW-1:0]    cnt_q;
    logic [WIDTH-1:0][CW-1:0]    cnt_d;
    logic [WIDTH-1:0]            lvl_q;
    logic [WIDTH-1:0]            lvl_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic [WIDTH-1:0]            upd;

    // Shift the raw inputs one stage further along the chain each clock.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.d;
        for (int k = 1; k < DEPTH; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Chain registers; reset loads RST_VAL into every stage.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[DEPTH-1];

    // Per-bit stability filter.  A bit that differs from q counts up.
    // Once it has already been seen FILT times and still differs, q takes
    // it.  Any return to q's level restarts the count, so short excursions
    // leave no trace.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        upd   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == FILT_C) begin
                upd[i]   = 1'b1;
                lvl_d[i] = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_d = upd & s;
        fall_d = upd & ~s;
    end

    // Filter state, q and strobes.  The strobes are loaded in the same
    // edge as q, so each lines up with the cycle q shows its new level.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            cnt_q  <= '0;
            lvl_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.q    = lvl_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.chg  = |(rise_q | fall_q);

endmodule
